// File: rtl/srlz_pkg.sv
// Shared definitions for the serializer family: FSM states, parity
// encodings and the frame-length rule.
package srlz_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Data bits plus one trailing parity bit when parity is enabled.
  function automatic int unsigned frame_len(input int unsigned dw, input int unsigned par);
    return dw + ((par != PAR_NONE) ? 1 : 0);
  endfunction

endpackage

// File: rtl/srlz_piso_hs.sv
// Parallel-in serial-out serializer with valid/ready intake, bit-rate
// strobe, optional trailing parity and zero-gap back-to-back frames.
module srlz_piso_hs
  import srlz_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LSB_FIRST  = 0,
  parameter int unsigned PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_en,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  sdo,
  output logic                  sframe,
  output logic                  slast,
  output logic                  busy
);

  localparam int unsigned FL = frame_len(DATA_WIDTH, PARITY);
  localparam int unsigned CW = $clog2(FL + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);

  state_t          state_q, state_d;
  logic [FL-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] ordered;
  logic [FL-1:0]   load_word;
  logic            last_bit;
  logic            accept;

  // The shift register always emits from its top bit, so LSB-first
  // transmission is handled by reversing the word at load time.
  always_comb begin
    ordered = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      ordered[i] = (LSB_FIRST != 0) ? s_data[DATA_WIDTH-1-i] : s_data[i];
    end
  end

  if (FL > DATA_WIDTH) begin : g_par
    logic par_bit;
    assign par_bit   = (^s_data) ^ (PARITY == PAR_ODD);
    assign load_word = {ordered, par_bit};
  end else begin : g_nopar
    assign load_word = ordered;
  end

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign s_ready  = rst_n && ((state_q == IDLE) || (last_bit && bit_en));
  assign accept   = s_valid && s_ready;

  assign busy   = (state_q == SHIFT);
  assign sframe = busy;
  assign slast  = last_bit;
  assign sdo    = busy & sreg_q[FL-1];

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sreg_d  = load_word;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (last_bit) begin
            if (accept) begin
              sreg_d = load_word;
              cnt_d  = '0;
            end else begin
              state_d = IDLE;
              sreg_d  = '0;
              cnt_d   = '0;
            end
          end else begin
            sreg_d = {sreg_q[FL-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_srlz_piso_hs.sv
// Directed bench for srlz_piso_hs: four instances (MSB-first, LSB-first,
// LSB-first even parity, LSB-first odd parity) share one stimulus.
module tb_srlz_piso_hs;

  logic       clk;
  logic       rst_n;
  logic       bit_en;
  logic       s_valid;
  logic [7:0] s_data;
  logic [3:0] rdy, sdo, fr, lst, bsy;

  int checks = 0;
  int errors = 0;

  srlz_piso_hs #(.DATA_WIDTH(8), .LSB_FIRST(0), .PARITY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy[0]), .sdo(sdo[0]), .sframe(fr[0]), .slast(lst[0]), .busy(bsy[0]));
  srlz_piso_hs #(.DATA_WIDTH(8), .LSB_FIRST(1), .PARITY(0)) u1 (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy[1]), .sdo(sdo[1]), .sframe(fr[1]), .slast(lst[1]), .busy(bsy[1]));
  srlz_piso_hs #(.DATA_WIDTH(8), .LSB_FIRST(1), .PARITY(1)) u2 (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy[2]), .sdo(sdo[2]), .sframe(fr[2]), .slast(lst[2]), .busy(bsy[2]));
  srlz_piso_hs #(.DATA_WIDTH(8), .LSB_FIRST(1), .PARITY(2)) u3 (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy[3]), .sdo(sdo[3]), .sframe(fr[3]), .slast(lst[3]), .busy(bsy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; bit_en = 1'b1; s_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'hFF; bit_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rdy !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", rdy); end
    checks++; if (bsy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b expected 0000", bsy); end
    checks++; if (sdo !== 4'h0) begin errors++; $display("FAIL reset_sdo: got %b expected 0000", sdo); end
    checks++; if (fr  !== 4'h0) begin errors++; $display("FAIL reset_sframe: got %b expected 0000", fr); end
    checks++; if (lst !== 4'h0) begin errors++; $display("FAIL reset_slast: got %b expected 0000", lst); end
    rst_n = 1'b1; s_valid = 1'b0;
    #1;
    checks++; if (rdy !== 4'hF) begin errors++; $display("FAIL release_ready: got %b expected 1111", rdy); end
  endtask

  task automatic test_msb_first;
    logic [7:0] exp;
    exp = 8'b0001_1110;
    do_reset();
    @(negedge clk);
    s_data = 8'h1E; s_valid = 1'b1; bit_en = 1'b1;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL msb_ready_c0: got %b expected 1", rdy[0]); end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      s_valid = 1'b0; s_data = 8'hFF;
      if (c <= 8) begin
        checks++; if (sdo[0] !== exp[8-c]) begin errors++; $display("FAIL msb_sdo c%0d: got %b expected %b", c, sdo[0], exp[8-c]); end
        checks++; if (fr[0] !== 1'b1) begin errors++; $display("FAIL msb_sframe c%0d: got %b expected 1", c, fr[0]); end
        checks++; if (lst[0] !== (c == 8)) begin errors++; $display("FAIL msb_slast c%0d: got %b expected %b", c, lst[0], (c == 8)); end
        checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL msb_busy c%0d: got %b expected 1", c, bsy[0]); end
      end else begin
        checks++; if (fr[0] !== 1'b0) begin errors++; $display("FAIL msb_end_sframe: got %b expected 0", fr[0]); end
        checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL msb_end_busy: got %b expected 0", bsy[0]); end
        checks++; if (sdo[0] !== 1'b0) begin errors++; $display("FAIL msb_end_sdo: got %b expected 0", sdo[0]); end
      end
    end
  endtask

  task automatic test_lsb_parity;
    logic [7:0] exp;
    exp = 8'b0111_1000;
    do_reset();
    @(negedge clk);
    s_data = 8'h1E; s_valid = 1'b1; bit_en = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      s_valid = 1'b0; s_data = 8'h00;
      if (c <= 8) begin
        checks++; if (sdo[1] !== exp[8-c]) begin errors++; $display("FAIL lsb_sdo c%0d: got %b expected %b", c, sdo[1], exp[8-c]); end
        checks++; if (lst[1] !== (c == 8)) begin errors++; $display("FAIL lsb_slast c%0d: got %b expected %b", c, lst[1], (c == 8)); end
        checks++; if (sdo[2] !== exp[8-c]) begin errors++; $display("FAIL even_sdo c%0d: got %b expected %b", c, sdo[2], exp[8-c]); end
        checks++; if (sdo[3] !== exp[8-c]) begin errors++; $display("FAIL odd_sdo c%0d: got %b expected %b", c, sdo[3], exp[8-c]); end
        checks++; if (lst[2] !== 1'b0) begin errors++; $display("FAIL even_slast c%0d: got %b expected 0", c, lst[2]); end
      end else if (c == 9) begin
        checks++; if (fr[1] !== 1'b0) begin errors++; $display("FAIL lsb_end_sframe: got %b expected 0", fr[1]); end
        checks++; if (sdo[2] !== 1'b0) begin errors++; $display("FAIL even_parity_bit: got %b expected 0", sdo[2]); end
        checks++; if (sdo[3] !== 1'b1) begin errors++; $display("FAIL odd_parity_bit: got %b expected 1", sdo[3]); end
        checks++; if (lst[3:2] !== 2'b11) begin errors++; $display("FAIL parity_slast: got %b expected 11", lst[3:2]); end
      end else begin
        checks++; if (fr[3:2] !== 2'b00) begin errors++; $display("FAIL parity_end_sframe: got %b expected 00", fr[3:2]); end
      end
    end
  endtask

  task automatic test_bit_en_spacing;
    logic [7:0] exp;
    exp = 8'b0001_1110;
    do_reset();
    @(negedge clk);
    s_data = 8'h1E; s_valid = 1'b1; bit_en = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (c <= 32) begin
        checks++; if (sdo[0] !== exp[7-(c-1)/4]) begin errors++; $display("FAIL slow_sdo c%0d: got %b expected %b", c, sdo[0], exp[7-(c-1)/4]); end
        checks++; if (fr[0] !== 1'b1) begin errors++; $display("FAIL slow_sframe c%0d: got %b expected 1", c, fr[0]); end
        checks++; if (lst[0] !== (c >= 29)) begin errors++; $display("FAIL slow_slast c%0d: got %b expected %b", c, lst[0], (c >= 29)); end
      end
      bit_en = ((c % 4) == 0);
      #1;
      if (c <= 32) begin
        checks++; if (rdy[0] !== (c == 32)) begin errors++; $display("FAIL slow_ready c%0d: got %b expected %b", c, rdy[0], (c == 32)); end
      end else begin
        checks++; if (fr[0] !== 1'b0) begin errors++; $display("FAIL slow_end_sframe: got %b expected 0", fr[0]); end
      end
    end
    bit_en = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] seq;
    seq = 16'hA53C;
    do_reset();
    @(negedge clk);
    s_data = 8'hA5; s_valid = 1'b1; bit_en = 1'b1;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_c0: got %b expected 1", rdy[0]); end
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) s_data = 8'h3C;
      if (c == 9) s_valid = 1'b0;
      #1;
      if (c <= 15) begin
        checks++; if (rdy[0] !== (c == 8)) begin errors++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, rdy[0], (c == 8)); end
      end
      if (c <= 16) begin
        checks++; if (sdo[0] !== seq[16-c]) begin errors++; $display("FAIL b2b_sdo c%0d: got %b expected %b", c, sdo[0], seq[16-c]); end
        checks++; if (fr[0] !== 1'b1) begin errors++; $display("FAIL b2b_sframe c%0d: got %b expected 1", c, fr[0]); end
      end else begin
        checks++; if (fr[0] !== 1'b0) begin errors++; $display("FAIL b2b_end_sframe: got %b expected 0", fr[0]); end
      end
    end
  endtask

  task automatic test_mid_frame;
    logic [7:0] w1, w2;
    logic       e;
    w1 = 8'h1E; w2 = 8'hC3;
    do_reset();
    @(negedge clk);
    s_data = w1; s_valid = 1'b1; bit_en = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) s_data = w2;
      if (c == 10) begin s_valid = 1'b0; s_data = 8'h00; end
      bit_en = (c != 8);
      #1;
      if (c <= 9) begin
        checks++; if (rdy[0] !== (c == 9)) begin errors++; $display("FAIL mid_ready c%0d: got %b expected %b", c, rdy[0], (c == 9)); end
      end
      if (c <= 17) begin
        if (c <= 8) e = w1[8-c];
        else if (c == 9) e = w1[0];
        else e = w2[17-c];
        checks++; if (sdo[0] !== e) begin errors++; $display("FAIL mid_sdo c%0d: got %b expected %b", c, sdo[0], e); end
      end else begin
        checks++; if (fr[0] !== 1'b0) begin errors++; $display("FAIL mid_end_sframe: got %b expected 0", fr[0]); end
      end
    end
    bit_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] w;
    w = 8'h96;
    do_reset();
    @(negedge clk);
    s_data = 8'h1E; s_valid = 1'b1; bit_en = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (fr[0] !== 1'b1) begin errors++; $display("FAIL rmid_sframe_before: got %b expected 1", fr[0]); end
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'h55;
    #1;
    checks++; if (rdy !== 4'h0) begin errors++; $display("FAIL rmid_ready_in_reset: got %b expected 0000", rdy); end
    @(negedge clk);
    checks++; if (bsy !== 4'h0) begin errors++; $display("FAIL rmid_busy: got %b expected 0000", bsy); end
    checks++; if (fr  !== 4'h0) begin errors++; $display("FAIL rmid_sframe: got %b expected 0000", fr); end
    checks++; if (sdo !== 4'h0) begin errors++; $display("FAIL rmid_sdo: got %b expected 0000", sdo); end
    rst_n = 1'b1; s_data = w;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rmid_ready_release: got %b expected 1", rdy[0]); end
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (c <= 8) begin
        checks++; if (sdo[0] !== w[8-c]) begin errors++; $display("FAIL rmid_sdo c%0d: got %b expected %b", c, sdo[0], w[8-c]); end
        checks++; if (lst[0] !== (c == 8)) begin errors++; $display("FAIL rmid_slast c%0d: got %b expected %b", c, lst[0], (c == 8)); end
      end else begin
        checks++; if (fr[0] !== 1'b0) begin errors++; $display("FAIL rmid_end_sframe: got %b expected 0", fr[0]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; bit_en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    test_reset();
    test_msb_first();
    test_lsb_parity();
    test_bit_en_spacing();
    test_back_to_back();
    test_mid_frame();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srlz_piso_hs.md
SRLZ_PISO_HS -- requirements
Module: srlz_piso_hs

Interface
REQ-001 Parameter DATA_WIDTH, default 8: parallel word width in bits; legal range 2..64.
REQ-002 Parameter LSB_FIRST, default 0: 0 = MSB transmitted first, 1 = LSB transmitted first.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = even parity bit appended, 2 = odd parity bit appended.
REQ-004 clk  input  1  rising-edge clock for all logic.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 bit_en  input  1  bit-rate strobe; serial output advances only on clk edges where bit_en=1.
REQ-007 s_valid  input  1  upstream word valid.
REQ-008 s_data  input  DATA_WIDTH  upstream parallel word.
REQ-009 s_ready  output  1  block can accept a word this cycle.
REQ-010 sdo  output  1  serial data out.
REQ-011 sframe  output  1  high while sdo carries a frame bit.
REQ-012 slast  output  1  high while sdo carries the final bit of a frame.
REQ-013 busy  output  1  high in SHIFT state.

Function
REQ-014 Frame length SHALL be FL = DATA_WIDTH + (PARITY != 0); parity bit SHALL be transmitted last.
REQ-015 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-016 A word SHALL be accepted only on a clk edge where s_valid=1 and s_ready=1; s_data SHALL be captured on that edge, and later s_data changes SHALL be ignored.
REQ-017 s_ready SHALL be combinational: 1 in IDLE, or 1 in SHIFT when slast=1 and bit_en=1; otherwise 0.
REQ-018 IDLE + accept -> SHIFT; the first frame bit SHALL appear on sdo in the cycle after accept (latency 1), regardless of bit_en.
REQ-019 In SHIFT, each bit SHALL be held on sdo until a clk edge with bit_en=1, then advance to the next bit.
REQ-020 On a bit_en edge with slast=1: if s_valid=1, the next word SHALL be loaded with zero idle cycles; otherwise FSM -> IDLE.
REQ-021 In IDLE, sdo, sframe and slast SHALL be 0.
REQ-022 The bit counter SHALL be $clog2(FL+1) bits wide, count 0..FL-1, and never wrap within a frame.
REQ-023 The parity bit SHALL be computed from the captured word at accept: even = XOR of all bits; odd = its inverse.
REQ-024 bit_en in IDLE SHALL have no effect.
REQ-025 busy SHALL equal (state == SHIFT).

Reset
REQ-026 While rst_n=0 at a clk edge: FSM -> IDLE, counter and shift register -> 0, and sdo/sframe/slast/busy -> 0.
REQ-027 s_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-028 Reset mid-frame SHALL abort the frame; no remaining bits SHALL be emitted and no word SHALL be accepted in the reset cycle.

Structure
REQ-029 Shared package srlz_pkg SHALL hold the state enum (IDLE, SHIFT), the parity encodings (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2) and the frame-length function.
REQ-030 The block SHALL be a single module; no sub-module is required.

Verification
REQ-031 DATA_WIDTH=8, LSB_FIRST=0, PARITY=0, bit_en=1, s_data=0x1E -> sdo 0,0,0,1,1,1,1,0 in cycles 1..8; sframe high in cycles 1..8; slast high in cycle 8 only.
REQ-032 LSB_FIRST=1, s_data=0x1E -> sdo 0,1,1,1,1,0,0,0; with PARITY=1, a 9th bit 0 follows; with PARITY=2, a 9th bit 1 follows.
REQ-033 bit_en pulsed every 4th cycle -> each bit is held exactly 4 cycles; the frame spans 32 cycles for DATA_WIDTH=8.
REQ-034 Back-to-back: s_valid held high with 0xA5 then 0x3C, bit_en=1 -> 16 consecutive sframe cycles and no gap; s_ready is high only in cycle 0 and cycle 8.
REQ-035 s_valid=1 during mid-frame -> s_ready=0 and the word is not consumed until the slast/bit_en edge.
REQ-036 rst_n=0 at bit 3 of a frame -> the next cycle has sdo=0, sframe=0, busy=0; after release, s_ready=1 and a new word transmits correctly.
